// File: rtl/serial_alu_ctrl.sv
// rtl/serial_alu_ctrl.sv - bit-serial sequencer driving an external 1-bit ALU slice, LSB first
// Optional zero flag output enabled by defining ALU_ZERO_FLAG_EN.
module serial_alu_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin_init,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             slice_f1,
    output logic             slice_f0,
    output logic             slice_a,
    output logic             slice_b,
    output logic             slice_cin,
    input  logic             slice_f,
    input  logic             slice_cout
`ifdef ALU_ZERO_FLAG_EN
    ,
    output logic             zero
`endif
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             carry;
    logic [1:0]       op_r;
    logic [CW-1:0]    cnt;
    logic             last_bit;
    logic             accept;

    assign last_bit = (cnt == CW'(WIDTH - 1));
    assign accept   = start && (state != RUN);

    assign busy      = (state == RUN);
    assign done      = (state == DONE);
    assign slice_f1  = op_r[1];
    assign slice_f0  = op_r[0];
    assign slice_a   = busy & a_sh[0];
    assign slice_b   = busy & b_sh[0];
    assign slice_cin = busy & carry;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            carry  <= 1'b0;
            op_r   <= 2'b00;
            cnt    <= '0;
            result <= '0;
            cout   <= 1'b0;
        end else if (state == RUN) begin
            result <= {slice_f, result[WIDTH-1:1]};
            carry  <= slice_cout;
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            cnt    <= cnt + CW'(1);
            if (last_bit) begin
                cout  <= slice_cout;
                state <= DONE;
            end
        end else if (accept) begin
            a_sh   <= a;
            b_sh   <= b;
            carry  <= cin_init;
            op_r   <= op;
            cnt    <= '0;
            result <= '0;
            state  <= RUN;
        end else begin
            state <= IDLE;
        end
    end

`ifdef ALU_ZERO_FLAG_EN
    // Sticky OR of captured bits avoids a wide compare on the final word.
    logic any_one;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            any_one <= 1'b0;
            zero    <= 1'b0;
        end else if (state == RUN) begin
            any_one <= any_one | slice_f;
            if (last_bit) begin
                zero <= ~(any_one | slice_f);
            end
        end else if (accept) begin
            any_one <= 1'b0;
            zero    <= 1'b0;
        end
    end
`endif

endmodule
